// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte producers share one UART transmitter.
// Optional launch timeout in WAIT_BUSY is built only when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int NUM_CLIENTS  = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            req,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_CLIENTS-1:0]            ack,
    output logic [NUM_CLIENTS-1:0]            done,
    output logic                              tx_enable,
    output logic [DATA_WIDTH-1:0]             tx_data,
    input  logic                              tx_busy,
    output logic [$clog2(NUM_CLIENTS)-1:0]    grant_id,
    output logic                              arb_busy,
    output logic                              tx_timeout
);

    localparam int GW = $clog2(NUM_CLIENTS);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, SENDING} state_t;

    state_t                  state;
    logic [GW-1:0]           last;
    logic [GW-1:0]           sel;
    logic                    found;
    logic [DATA_WIDTH-1:0]   client_byte [NUM_CLIENTS];

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
        assign client_byte[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        int unsigned   idx;
        logic [GW-1:0] cand;
        idx   = 0;
        cand  = '0;
        sel   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
            idx  = (32'(last) + k) % NUM_CLIENTS;
            cand = idx[GW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign arb_busy = (state != IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
`else
    assign tx_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= GW'(NUM_CLIENTS - 1);
            ack       <= '0;
            done      <= '0;
            tx_enable <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tx_timeout <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            ack       <= '0;
            done      <= '0;
            tx_enable <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tx_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found && !tx_busy) begin
                        tx_data   <= client_byte[sel];
                        grant_id  <= sel;
                        ack[sel]  <= 1'b1;
                        last      <= sel;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_enable <= 1'b1;
                    state     <= WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= SENDING;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    // Abandon the launch; the pointer keeps its advance so others get served.
                    else if (wait_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        tx_timeout <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                SENDING: begin
                    if (!tx_busy) begin
                        done[grant_id] <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames
// against a round-robin reference model and a behavioural UART loopback.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        tx_enable;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        tx_timeout;

    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int done_cnt = 0;
    int en_cnt = 0;
    int model_last;
    int obs_grant;
    int frame_len = 4;
    int ucnt = 0;
    bit force_busy = 0;
    bit stuck = 0;
    bit have_byte = 0;
    logic [7:0] cur_byte;
    logic [1:0] cur_grant;
    logic [7:0] rx_q [$];

    uart_tx_arbiter #(
        .NUM_CLIENTS(4),
        .DATA_WIDTH(8),
        .BUSY_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .done(done),
        .tx_enable(tx_enable),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .arb_busy(arb_busy),
        .tx_timeout(tx_timeout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: rotate so client last+1 sits at bit 0, then take the lowest set bit.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        logic [7:0] dbl;
        logic [3:0] rot;
        dbl = {r, r};
        rot = 4'(dbl >> ((last + 1) % 4));
        for (int k = 0; k < 4; k++)
            if (rot[k]) return (last + 1 + k) % 4;
        return -1;
    endfunction

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_ack"}, ack, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_tx_enable"}, tx_enable, 0);
        chk({pfx, "_tx_data"}, tx_data, 0);
        chk({pfx, "_grant_id"}, grant_id, 0);
        chk({pfx, "_arb_busy"}, arb_busy, 0);
        chk({pfx, "_tx_timeout"}, tx_timeout, 0);
    endtask

    task automatic run_frame(input logic [3:0] r, input logic [31:0] d, input int flen, input bit chk_lat);
        int eg, n, a0;
        logic [7:0] eb, got;
        eg = rr_pick(r, model_last);
        eb = d[eg*8 +: 8];
        a0 = ack_cnt;
        frame_len = flen;
        req = r;
        req_data = d;
        n = 0;
        do begin @(negedge clk); n++; end while (ack === 4'b0 && n < 20);
        if (chk_lat) chk("ack_latency", n, 1);
        chk("ack_onehot", ack, 32'd1 << eg);
        chk("grant_id", grant_id, eg);
        chk("tx_data_latch", tx_data, eb);
        obs_grant = int'(grant_id);
        model_last = eg;
        @(negedge clk);
        chk("tx_enable_after_ack", tx_enable, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (done === 4'b0 && n < 300);
        chk("done_onehot", done, 32'd1 << eg);
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        chk("rx_byte", got, eb);
        chk("acks_per_frame", ack_cnt - a0, 1);
    endtask

    // UART loopback model and per-cycle invariant monitor.
    initial begin
        tx_busy = 0;
        forever begin
            @(negedge clk);
            chk("pulse_exclusive", $countones({ack, done, tx_enable, tx_timeout}) <= 1, 1);
`ifndef UART_TX_ARB_TIMEOUT_EN
            chk("timeout_tied_low", tx_timeout, 0);
`endif
            if (ack !== 4'b0) ack_cnt++;
            if (done !== 4'b0) done_cnt++;
            if (tx_enable === 1'b1) en_cnt++;
            if (tx_busy && !reset && have_byte) begin
                chk("tx_data_stable", tx_data, cur_byte);
                chk("grant_stable", grant_id, cur_grant);
            end
            if (reset) begin
                tx_busy = 0;
                ucnt = 0;
                rx_q.delete();
            end else if (force_busy) begin
                tx_busy = 1;
            end else if (ucnt > 0) begin
                ucnt--;
                tx_busy = (ucnt != 0);
            end else if (tx_enable === 1'b1 && !stuck) begin
                tx_busy = 1;
                ucnt = frame_len;
                rx_q.push_back(tx_data);
                cur_byte = tx_data;
                cur_grant = grant_id;
                have_byte = 1;
            end else begin
                tx_busy = 0;
            end
        end
    end

    initial begin
        int n, a0, e0, d0, eg;
        reset = 1;
        req = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 0;
        model_last = 3;

        // Contention: all four request, grants rotate 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            run_frame(4'b1111, 32'h13121110, 3, 1);
            chk("contention_grant", obs_grant, i % 4);
        end
        req = '0;

        // Single request from client 1
        run_frame(4'b0010, 32'h0000A500, 5, 1);
        chk("single_grant", obs_grant, 1);
        req = '0;

        // Rotation skip after grant to client 2
        run_frame(4'b0100, $urandom, 2, 1);
        run_frame(4'b0101, $urandom, 2, 1);
        chk("rot_skip_first", obs_grant, 0);
        run_frame(4'b0101, $urandom, 2, 1);
        chk("rot_skip_second", obs_grant, 2);
        req = '0;

        // Busy guard: no grant while the UART reports busy in IDLE
        force_busy = 1;
        repeat (2) @(negedge clk);
        a0 = ack_cnt;
        e0 = en_cnt;
        req = 4'b0001;
        repeat (10) @(negedge clk);
        chk("guard_no_ack", ack_cnt - a0, 0);
        chk("guard_no_enable", en_cnt - e0, 0);
        force_busy = 0;
        run_frame(4'b0001, $urandom, 3, 0);
        chk("guard_release_grant", obs_grant, 0);
        req = '0;

        // A request dropped before it is acknowledged is ignored
        a0 = ack_cnt;
        eg = rr_pick(4'b0001, model_last);
        frame_len = 10;
        req = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (ack === 4'b0 && n < 20);
        chk("drop_first_ack", ack, 32'd1 << eg);
        model_last = eg;
        req = '0;
        repeat (2) @(negedge clk);
        req = 4'b0100;
        repeat (3) @(negedge clk);
        req = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (done === 4'b0 && n < 100);
        chk("drop_done", done, 32'd1 << eg);
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        repeat (6) @(negedge clk);
        chk("drop_ignored", ack_cnt - a0, 1);
        chk("drop_idle", arb_busy, 0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 12; i++)
            run_frame(4'($urandom_range(1, 15)), $urandom, $urandom_range(1, 12), 1);
        req = '0;

        // Reset mid-frame
        frame_len = 40;
        req = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (ack === 4'b0 && n < 20);
        req = '0;
        @(negedge clk);
        chk("midreset_enable", tx_enable, 1);
        repeat (20) @(negedge clk);
        d0 = done_cnt;
        reset = 1;
        @(negedge clk);
        chk_reset_vals("midreset");
        @(negedge clk);
        reset = 0;
        model_last = 3;
        repeat (5) @(negedge clk);
        chk("midreset_no_done", done_cnt - d0, 0);
        run_frame(4'b1000, $urandom, 3, 1);
        chk("post_reset_grant", obs_grant, 3);
        req = '0;

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Launch timeout: the UART never raises busy
        stuck = 1;
        d0 = done_cnt;
        eg = rr_pick(4'b0001, model_last);
        req = 4'b0001;
        n = 0;
        do begin @(negedge clk); n++; end while (ack === 4'b0 && n < 20);
        chk("to_ack", ack, 32'd1 << eg);
        model_last = eg;
        req = '0;
        @(negedge clk);
        chk("to_enable", tx_enable, 1);
        n = 0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (tx_timeout === 1'b1) n++;
        end
        chk("to_not_early", n, 0);
        @(negedge clk);
        chk("to_pulse", tx_timeout, 1);
        chk("to_idle", arb_busy, 0);
        @(negedge clk);
        chk("to_idle_next", arb_busy, 0);
        chk("to_single_pulse", tx_timeout, 0);
        chk("to_no_done", done_cnt - d0, 0);
        stuck = 0;
        run_frame(4'b0011, $urandom, 3, 1);
        chk("to_pointer_advanced", obs_grant, 1);
        req = '0;
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
